ctrl_req_queue: RTL
===================

Name: ctrl_req_queue

Overview:
- Host-side request buffer directly upstream of the controller FSM.
- Accepts read/write requests from the host over a valid/ready handshake and stores them in an in-order FIFO.
- Decodes each flat address into bank group/bank/row/column and presents one command at a time to the FSM.
- Produces a page-hit hint from the row last issued to the FSM, and holds all commands until DRAM initialisation completes.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, ≥2
- ROW_W, 15, row address width
- COL_W, 10, column address width
- DATA_W, 64, write payload per request
- ID_W, 4, request tag width
- ADDR_W (derived), ROW_W+COL_W+4, host address width

Ports:
- clock  in  1  controller clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- init_done  in  1  DRAM initialisation finished; level
- refresh_done  in  1  one-cycle pulse; all banks precharged by refresh
- host_req_valid  in  1  host request present
- host_req_ready  out  1  queue can accept
- host_req_rw  in  1  1=read, 0=write
- host_req_addr  in  ADDR_W  flat address: col[COL_W-1:0], ba next 2b, bg next 2b, row top ROW_W bits
- host_req_wdata  in  DATA_W  write data; ignored for reads
- host_req_id  in  ID_W  request tag
- cmd_valid  out  1  command available to FSM
- cmd_ready  in  1  FSM takes command
- cmd_rw  out  1  as host_req_rw
- cmd_bg  out  2  bank group
- cmd_ba  out  2  bank
- cmd_row  out  ROW_W  row
- cmd_col  out  COL_W  column
- cmd_wdata  out  DATA_W  write data
- cmd_id  out  ID_W  tag
- cmd_page_hit  out  1  head entry targets last issued bg/ba/row with the page still open
- q_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
Reset:
- reset asserted asynchronously clears the following: wr/rd pointers, count=0, cmd_valid=0, host_req_ready=0 (held 0 while reset high), last_valid=0, cmd_page_hit=0.
- Entry contents are don't-care.
- The first edge after reset deasserts gives host_req_ready=1.
- Reset mid-operation discards all queued requests; no partial command survives.

Push:
- Occurs when host_req_valid & host_req_ready at a clock edge.
- The entry stores rw, decoded bg/ba/row/col, wdata and id.
- host_req_ready = ~full (count==DEPTH gives 0). There is no same-cycle bypass when full, even if a pop occurs in the same cycle.
- host_req_ready does not depend on init_done, so the queue fills during initialisation.

Pop:
- Occurs when cmd_valid & cmd_ready.
- cmd_valid = ~empty & init_done.
- cmd_* show the head entry (show-ahead) and are stable while cmd_valid & ~cmd_ready.
- cmd_ready while cmd_valid=0 has no effect.

Latency:
- A request pushed into an empty queue at edge N drives cmd_valid=1 from edge N (registered count), i.e. it is visible to the FSM in the cycle after acceptance.
- There is no combinational path from host_req_* to cmd_*.

Pointers and count:
- Pointers wrap modulo DEPTH.
- Push and pop in the same cycle leave count unchanged, and both pointers advance.
- Count never exceeds DEPTH and never underflows.

Page tracking:
- On each pop, register last_bg/ba/row from the popped entry and set last_valid=1.
- refresh_done clears last_valid.
- If refresh_done and a pop coincide, the pop wins: last_valid=1 with the new row.
- cmd_page_hit = cmd_valid & last_valid & (head bg,ba,row == last).
- cmd_page_hit is combinational from registers only.

Ordering:
- Strict FIFO with no reordering, no read/write merging, and no address-hazard checks.

Test Plan:
1. Reset, init_done=0, push 3 requests → q_count=3, cmd_valid=0, host_req_ready=1. Raise init_done → cmd_valid=1 next cycle, head id=0.
2. Push addr with row=0x1A2B, bg=2, ba=1, col=0x3F → cmd_row=0x1A2B, cmd_bg=2, cmd_ba=1, cmd_col=0x03F.
3. Push 8 with cmd_ready=0 → q_count=8, host_req_ready=0. A 9th valid is held and not accepted. Pulse cmd_ready once → count 7, ready=1, 9th accepted next edge, ids pop in order 0..8.
4. Continuous push and pop for 20 cycles at count=4 → q_count stays 4, pointers wrap twice, no id lost or duplicated.
5. Pop row 0x10 on bg0/ba0, then head is also row 0x10 on bg0/ba0 → cmd_page_hit=1. Pulse refresh_done → cmd_page_hit=0. Repeat with refresh_done coincident with the pop → last_valid=1.
6. Assert reset with 5 entries queued and cmd_valid=1 → cmd_valid=0 immediately, q_count=0. After release the queue is empty and ready=1.

Source files
------------

// File: rtl/ctrl_req_queue.sv
// Host request FIFO in front of the controller FSM.
// Decodes flat addresses and tracks the last issued row for page hits.
module ctrl_req_queue #(
    parameter  int DEPTH  = 8,
    parameter  int ROW_W  = 15,
    parameter  int COL_W  = 10,
    parameter  int DATA_W = 64,
    parameter  int ID_W   = 4,
    localparam int ADDR_W = ROW_W + COL_W + 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init_done,
    input  logic              refresh_done,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic              host_req_rw,
    input  logic [ADDR_W-1:0] host_req_addr,
    input  logic [DATA_W-1:0] host_req_wdata,
    input  logic [ID_W-1:0]   host_req_id,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_rw,
    output logic [1:0]        cmd_bg,
    output logic [1:0]        cmd_ba,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [COL_W-1:0]  cmd_col,
    output logic [DATA_W-1:0] cmd_wdata,
    output logic [ID_W-1:0]   cmd_id,
    output logic              cmd_page_hit,
    output logic [CNT_W-1:0]  q_count
);

    logic              r_rw    [DEPTH];
    logic [1:0]        r_bg    [DEPTH];
    logic [1:0]        r_ba    [DEPTH];
    logic [ROW_W-1:0]  r_row   [DEPTH];
    logic [COL_W-1:0]  r_col   [DEPTH];
    logic [DATA_W-1:0] r_wdata [DEPTH];
    logic [ID_W-1:0]   r_id    [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ready;
    logic              r_last_valid;
    logic [1:0]        r_last_bg;
    logic [1:0]        r_last_ba;
    logic [ROW_W-1:0]  r_last_row;

    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_same_page;

    assign w_push = host_req_valid & r_ready;
    assign w_pop  = cmd_valid & cmd_ready;

    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Ready is registered from the next count, so a pop while full only
    // reopens the queue on the following cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_rw[r_wr_ptr]    <= host_req_rw;
            r_col[r_wr_ptr]   <= host_req_addr[COL_W-1:0];
            r_ba[r_wr_ptr]    <= host_req_addr[COL_W+1:COL_W];
            r_bg[r_wr_ptr]    <= host_req_addr[COL_W+3:COL_W+2];
            r_row[r_wr_ptr]   <= host_req_addr[ADDR_W-1:COL_W+4];
            r_wdata[r_wr_ptr] <= host_req_wdata;
            r_id[r_wr_ptr]    <= host_req_id;
        end
    end

    // A pop coinciding with refresh_done re-opens tracking on the new row.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_valid <= 1'b0;
            r_last_bg    <= '0;
            r_last_ba    <= '0;
            r_last_row   <= '0;
        end else if (w_pop) begin
            r_last_valid <= 1'b1;
            r_last_bg    <= r_bg[r_rd_ptr];
            r_last_ba    <= r_ba[r_rd_ptr];
            r_last_row   <= r_row[r_rd_ptr];
        end else if (refresh_done) begin
            r_last_valid <= 1'b0;
        end
    end

    assign host_req_ready = r_ready;
    assign q_count        = r_count;
    assign cmd_valid      = (r_count != '0) & init_done;

    assign cmd_rw    = r_rw[r_rd_ptr];
    assign cmd_bg    = r_bg[r_rd_ptr];
    assign cmd_ba    = r_ba[r_rd_ptr];
    assign cmd_row   = r_row[r_rd_ptr];
    assign cmd_col   = r_col[r_rd_ptr];
    assign cmd_wdata = r_wdata[r_rd_ptr];
    assign cmd_id    = r_id[r_rd_ptr];

    assign w_same_page = (cmd_bg == r_last_bg) &&
                         (cmd_ba == r_last_ba) &&
                         (cmd_row == r_last_row);

    assign cmd_page_hit = cmd_valid & r_last_valid & w_same_page;

endmodule
